uart_tx_arbiter: RTL and testbench



---
 rtl/uart_tx_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one 8N1 UART transmitter between NUM_REQ byte-stream
// requesters. Round-robin arbitration per packet; the grant stays with one
// requester until it sends a byte marked last. Bytes are paced on tx_busy.
// Build macro UART_ARB_LOCK_TIMEOUT_EN: release an owner that idles in HOLD
// for LOCK_IDLE_MAX cycles.
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int LOCK_IDLE_MAX = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ack,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic                 grant_valid,
  output logic [2:0]           grant_id
);

  typedef enum logic [1:0] {ARB, WAIT_HI, WAIT_LO, HOLD} state_t;

  // Marker block: only present for out-of-range parameter sets.
  if (NUM_REQ < 1 || NUM_REQ > 8 || LOCK_IDLE_MAX < 1) begin : g_param_range_invalid
  end

  state_t               state, state_n;
  logic [2:0]           rr_ptr, rr_ptr_n;
  logic                 last_r, last_n;
  logic                 tx_start_n;
  logic [7:0]           tx_data_n;
  logic [NUM_REQ-1:0]   req_ack_n;
  logic                 grant_valid_n;
  logic [2:0]           grant_id_n;

  // Requester inputs widened to the 8-requester maximum so a 3-bit index
  // selects them without width mismatch.
  logic [7:0]           req_pad;
  logic [7:0]           last_pad;
  logic [63:0]          data_pad;

  logic                 win_found;
  logic [2:0]           win_id;
  logic [3:0]           cand_sum;
  logic                 issue;
  logic [2:0]           issue_id;
  logic [2:0]           ptr_after_owner;

`ifdef UART_ARB_LOCK_TIMEOUT_EN
  localparam int CW = $clog2(LOCK_IDLE_MAX + 1);
  logic [CW-1:0]        idle_cnt, idle_cnt_n;
`endif

  assign req_pad  = 8'(req);
  assign last_pad = 8'(req_last);
  assign data_pad = 64'(req_data);

  // The owner just served drops to lowest priority on the next arbitration.
  assign ptr_after_owner = (grant_id >= 3'(NUM_REQ - 1)) ? '0 : grant_id + 3'd1;

  // Round-robin search: first set req at or above rr_ptr, wrapping at NUM_REQ-1.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand_sum  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand_sum = {1'b0, rr_ptr} + 4'(i);
      if (cand_sum >= 4'(NUM_REQ)) begin
        cand_sum = cand_sum - 4'(NUM_REQ);
      end
      if (!win_found && req_pad[cand_sum[2:0]]) begin
        win_found = 1'b1;
        win_id    = cand_sum[2:0];
      end
    end
  end

  // Next-state and next-output decode; issue from ARB and HOLD share one path.
  always_comb begin
    state_n       = state;
    rr_ptr_n      = rr_ptr;
    last_n        = last_r;
    tx_start_n    = 1'b0;
    tx_data_n     = tx_data;
    req_ack_n     = '0;
    grant_valid_n = grant_valid;
    grant_id_n    = grant_id;
    issue         = 1'b0;
    issue_id      = grant_id;
`ifdef UART_ARB_LOCK_TIMEOUT_EN
    idle_cnt_n    = '0;
`endif
    unique case (state)
      ARB: begin
        if (!tx_busy && win_found) begin
          issue    = 1'b1;
          issue_id = win_id;
        end
      end
      WAIT_HI: begin
        if (tx_busy) begin
          state_n = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (!tx_busy) begin
          if (last_r) begin
            grant_valid_n = 1'b0;
            rr_ptr_n      = ptr_after_owner;
            state_n       = ARB;
          end else begin
            state_n = HOLD;
          end
        end
      end
      HOLD: begin
        if (req_pad[grant_id]) begin
          issue    = 1'b1;
          issue_id = grant_id;
        end
`ifdef UART_ARB_LOCK_TIMEOUT_EN
        else if (idle_cnt == CW'(LOCK_IDLE_MAX - 1)) begin
          grant_valid_n = 1'b0;
          rr_ptr_n      = ptr_after_owner;
          state_n       = ARB;
        end else begin
          idle_cnt_n = idle_cnt + 1'b1;
        end
`endif
      end
      default: state_n = ARB;
    endcase

    if (issue) begin
      tx_start_n    = 1'b1;
      tx_data_n     = data_pad[{issue_id, 3'b000} +: 8];
      last_n        = last_pad[issue_id];
      grant_valid_n = 1'b1;
      grant_id_n    = issue_id;
      state_n       = WAIT_HI;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        req_ack_n[i] = (3'(i) == issue_id);
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ARB;
      rr_ptr      <= '0;
      last_r      <= 1'b0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      req_ack     <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
    end else begin
      state       <= state_n;
      rr_ptr      <= rr_ptr_n;
      last_r      <= last_n;
      tx_start    <= tx_start_n;
      tx_data     <= tx_data_n;
      req_ack     <= req_ack_n;
      grant_valid <= grant_valid_n;
      grant_id    <= grant_id_n;
    end
  end

`ifdef UART_ARB_LOCK_TIMEOUT_EN
  // Idle counter for the locked owner; cleared whenever HOLD is not idling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt_n;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter (default build, NUM_REQ=4): directed
// sequences, a vector table for arbitration order, and randomized packet
// rounds checked against a packet-level round-robin model.
module tb_uart_tx_arbiter;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_last = '0;
  logic [N-1:0]   req_ack;
  logic           tx_start;
  logic [7:0]     tx_data;
  logic           tx_busy;
  logic           grant_valid;
  logic [2:0]     grant_id;

  int passed = 0;
  int total  = 0;
  int unsigned busy_len = 3;
  int unsigned busy_cnt;
  bit auto_drv = 1'b0;

  typedef struct packed {
    logic [2:0] gid;
    logic [2:0] aid;
    logic [7:0] data;
  } obs_t;

  typedef struct packed {
    logic       pre_en;
    logic [2:0] pre_id;
    logic [3:0] mask;
    logic [2:0] exp_id;
    logic [7:0] exp_byte;
  } vec_t;

  logic [8:0]  pq [N][$];   // per-requester pending bytes {last, data}
  logic [8:0]  mq [N][$];   // model working copy
  logic [10:0] expq [$];    // expected {id, data}
  obs_t        obs [$];
  vec_t        vecs [12];

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N), .LOCK_IDLE_MAX(16)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
    .req_last(req_last), .req_ack(req_ack), .tx_start(tx_start),
    .tx_data(tx_data), .tx_busy(tx_busy), .grant_valid(grant_valid),
    .grant_id(grant_id)
  );

  // UART transmitter stand-in: busy for busy_len cycles after each start.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_cnt <= 0;
    else if (tx_start) busy_cnt <= busy_len;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: actual 0x%0h, required 0x%0h", name, act, exp);
  endtask

  task automatic fail_bound(input string name);
    total++;
    $display("FAIL %s: actual no event within bound, required event", name);
  endtask

  function automatic bit pq_empty();
    for (int i = 0; i < N; i++) if (pq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // One cycle: sample at the falling edge, record issues, then drive requesters.
  task automatic tick();
    obs_t o;
    logic [8:0] b;
    @(negedge clk);
    if (tx_start) begin
      o.gid  = grant_id;
      o.data = tx_data;
      o.aid  = 3'd7;
      for (int i = 0; i < N; i++) if (req_ack[i]) o.aid = 3'(i);
      obs.push_back(o);
      check("ack_count", 32'($countones(req_ack)), 32'd1);
    end
    if (auto_drv) begin
      for (int i = 0; i < N; i++) begin
        if (req_ack[i] && pq[i].size() != 0) b = pq[i].pop_front();
        if (pq[i].size() != 0) begin
          req[i]              = 1'b1;
          req_data[8*i +: 8]  = pq[i][0][7:0];
          req_last[i]         = pq[i][0][8];
        end else begin
          req[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic do_reset();
    auto_drv = 1'b0;
    req = '0; req_data = '0; req_last = '0;
    for (int i = 0; i < N; i++) pq[i].delete();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    bit done = 1'b0;
    while (!done) begin
      tick();
      n++;
      if (!grant_valid && !tx_busy && !tx_start && pq_empty() && req == '0) done = 1'b1;
      else if (n >= budget) begin
        fail_bound("idle_wait");
        done = 1'b1;
      end
    end
  endtask

  // Packet-level round-robin: whole packets, owner moves to lowest priority.
  task automatic build_expected();
    int ptr = 0;
    int w;
    logic [8:0] b;
    bit more = 1'b1;
    expq.delete();
    for (int i = 0; i < N; i++) mq[i] = pq[i];
    while (more) begin
      w = -1;
      for (int k = 0; k < N; k++) begin
        if (w < 0 && mq[(ptr + k) % N].size() != 0) w = (ptr + k) % N;
      end
      if (w < 0) more = 1'b0;
      else begin
        do begin
          b = mq[w].pop_front();
          expq.push_back({3'(w), b[7:0]});
        end while (!b[8] && mq[w].size() != 0);
        ptr = (w + 1) % N;
      end
    end
  endtask

  task automatic run_round(input string tag);
    build_expected();
    obs.delete();
    auto_drv = 1'b1;
    wait_idle(4000);
    auto_drv = 1'b0;
    check({tag, "_count"}, 32'(obs.size()), 32'(expq.size()));
    for (int k = 0; k < obs.size() && k < expq.size(); k++) begin
      check($sformatf("%s_gid[%0d]", tag, k), 32'(obs[k].gid), 32'(expq[k][10:8]));
      check($sformatf("%s_ackid[%0d]", tag, k), 32'(obs[k].aid), 32'(expq[k][10:8]));
      check($sformatf("%s_byte[%0d]", tag, k), 32'(obs[k].data), 32'(expq[k][7:0]));
    end
  endtask

  initial begin
    int stray;
    bit seen;
    vecs = '{
      '{1'b0, 3'd0, 4'b0110, 3'd1, 8'h11},
      '{1'b0, 3'd0, 4'b1000, 3'd3, 8'h33},
      '{1'b0, 3'd0, 4'b1111, 3'd0, 8'h00},
      '{1'b1, 3'd0, 4'b0001, 3'd0, 8'h00},
      '{1'b1, 3'd0, 4'b1011, 3'd1, 8'h11},
      '{1'b1, 3'd1, 4'b0011, 3'd0, 8'h00},
      '{1'b1, 3'd2, 4'b0111, 3'd0, 8'h00},
      '{1'b1, 3'd3, 4'b1110, 3'd1, 8'h11},
      '{1'b1, 3'd1, 4'b1110, 3'd2, 8'h22},
      '{1'b1, 3'd2, 4'b1110, 3'd3, 8'h33},
      '{1'b1, 3'd3, 4'b1111, 3'd0, 8'h00},
      '{1'b1, 3'd2, 4'b1100, 3'd3, 8'h33}
    };

    // Reset state.
    do_reset();
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_req_ack", 32'(req_ack), 32'd0);
    check("rst_grant_valid", 32'(grant_valid), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);

    // Single-byte packet from requester 0, then rr_ptr probe.
    req = 4'b0001; req_data[7:0] = 8'h41; req_last = 4'b0001;
    tick();
    check("a_tx_start", 32'(tx_start), 32'd1);
    check("a_tx_data", 32'(tx_data), 32'h41);
    check("a_req_ack", 32'(req_ack), 32'b0001);
    check("a_grant_valid", 32'(grant_valid), 32'd1);
    check("a_grant_id", 32'(grant_id), 32'd0);
    req = '0;
    tick();
    check("a_start_pulse", 32'(tx_start), 32'd0);
    check("a_ack_pulse", 32'(req_ack), 32'd0);
    wait_idle(100);
    req = 4'b0011; req_data[7:0] = 8'h50; req_data[15:8] = 8'h51; req_last = 4'b0011;
    tick();
    check("a_rr_gid", 32'(grant_id), 32'd1);
    check("a_rr_byte", 32'(tx_data), 32'h51);
    req = '0;
    wait_idle(100);

    // Reset while waiting for busy to fall.
    req = 4'b0100; req_data[23:16] = 8'h77; req_last = 4'b0000;
    tick();
    check("b_gid", 32'(grant_id), 32'd2);
    req = '0;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      tick();
      if (tx_busy) seen = 1'b1;
    end
    if (!seen) fail_bound("b_busy_rise");
    tick();
    rst_n = 1'b0;
    #1;
    check("b_rst_tx_start", 32'(tx_start), 32'd0);
    check("b_rst_tx_data", 32'(tx_data), 32'd0);
    check("b_rst_req_ack", 32'(req_ack), 32'd0);
    check("b_rst_grant_valid", 32'(grant_valid), 32'd0);
    check("b_rst_grant_id", 32'(grant_id), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    req = 4'b0110; req_data[15:8] = 8'h61; req_data[23:16] = 8'h62; req_last = 4'b0110;
    tick();
    check("b_after_rst_gid", 32'(grant_id), 32'd1);
    check("b_after_rst_byte", 32'(tx_data), 32'h61);
    req = '0;
    wait_idle(100);

    // Locked owner idles in HOLD; another requester must wait.
    do_reset();
    req = 4'b0001; req_data[7:0] = 8'hA0; req_last = 4'b0000;
    tick();
    check("c_gid", 32'(grant_id), 32'd0);
    req = 4'b0010; req_data[15:8] = 8'hB1; req_last = 4'b0010;
    stray = 0;
    for (int n = 0; n < 1000; n++) begin
      tick();
      if (tx_start || req_ack != '0) stray++;
    end
    check("c_hold_stray", 32'(stray), 32'd0);
    check("c_hold_valid", 32'(grant_valid), 32'd1);
    check("c_hold_gid", 32'(grant_id), 32'd0);
    req = 4'b0011; req_data[7:0] = 8'hA1; req_last = 4'b0011;
    tick();
    check("c_resume_start", 32'(tx_start), 32'd1);
    check("c_resume_byte", 32'(tx_data), 32'hA1);
    check("c_resume_gid", 32'(grant_id), 32'd0);
    req = 4'b0010;
    seen = 1'b0;
    for (int n = 0; n < 50 && !seen; n++) begin
      tick();
      if (tx_start) seen = 1'b1;
    end
    if (!seen) fail_bound("c_next_grant");
    else begin
      check("c_next_gid", 32'(grant_id), 32'd1);
      check("c_next_byte", 32'(tx_data), 32'hB1);
    end
    req = '0;
    wait_idle(100);

    // Arbitration order table.
    for (int v = 0; v < 12; v++) begin
      do_reset();
      if (vecs[v].pre_en) begin
        req[vecs[v].pre_id] = 1'b1;
        req_last = '1;
        tick();
        req = '0;
        wait_idle(100);
      end
      for (int i = 0; i < N; i++) req_data[8*i +: 8] = 8'(8'h11 * i);
      req_last = '1;
      req = vecs[v].mask;
      tick();
      check($sformatf("vec%0d_gid", v), 32'(grant_id), 32'(vecs[v].exp_id));
      check($sformatf("vec%0d_byte", v), 32'(tx_data), 32'(vecs[v].exp_byte));
      check($sformatf("vec%0d_ack", v), 32'(req_ack), 32'd1 << vecs[v].exp_id);
      req = '0;
      wait_idle(100);
    end

    // Directed packet rounds.
    do_reset();
    pq[0].push_back({1'b0, 8'hA0}); pq[0].push_back({1'b0, 8'hA1}); pq[0].push_back({1'b1, 8'hA2});
    pq[3].push_back({1'b1, 8'h3C});
    run_round("pkt3");
    do_reset();
    for (int k = 0; k < 4; k++) begin
      pq[0].push_back({1'b1, 8'(8'hC0 + k)});
      pq[1].push_back({1'b1, 8'(8'hD0 + k)});
    end
    run_round("alt");
    do_reset();
    pq[1].push_back({1'b1, 8'h11});
    pq[2].push_back({1'b1, 8'h22});
    run_round("pair");

    // Randomized rounds.
    for (int r = 0; r < 6; r++) begin
      busy_len = $urandom_range(1, 4);
      do_reset();
      for (int i = 0; i < N; i++) begin
        int np;
        np = $urandom_range(0, 3);
        for (int p = 0; p < np; p++) begin
          int len;
          len = $urandom_range(1, 4);
          for (int b = 0; b < len; b++) pq[i].push_back({1'(b == len - 1), 8'($urandom)});
        end
      end
      run_round($sformatf("rnd%0d", r));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
